conv_kxk_bitserial_pim: RTL and testbench
=========================================

// Module: conv_kxk_bitserial_pim
// PURPOSE
//   Parametrised KxK PIM convolution engine that streams input bit-slices through one
//   crossbar MAC and recombines them by shift-and-add. The earlier design replicated
//   crossbars per slice; this block time-multiplexes a single crossbar over P_IN/SLICE cycles.
//   It adds valid/ready handshakes, DEPTH programmable weight banks, and ADC saturation.
//   It sits between the line-buffer window generator and the output accumulator/activation stage.
// PARAMETERS
//   K       5   kernel edge; N = K*K taps
//   P_IN    12  input activation width (unsigned)
//   P_W     8   weight width (unsigned)
//   SLICE   3   input bits applied to the crossbar per cycle
//   ADC_P   16  ADC output width; per-slice partial saturates to 2^ADC_P-1
//   DEPTH   4   number of weight banks (kernels) held
//   derived: NSLICE = ceil(P_IN/SLICE); OUT_W = ADC_P + NSLICE*SLICE; BW = clogb2(DEPTH), min 1
// PORTS
//   clk        in   1          clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   w_we       in   1          weight write strobe
//   w_bank     in   BW         weight bank to write
//   w_idx      in   clogb2(N)  tap index 0..N-1
//   w_data     in   P_W        weight value
//   w_err      out  1          1-cycle pulse: write dropped (engine busy or w_idx>=N)
//   in_valid   in   1          window valid
//   in_ready   out  1          engine can accept a window
//   in_data    in   N*P_IN     window; tap i at [i*P_IN +: P_IN]
//   in_bank    in   BW         weight bank for this window
//   out_valid  out  1          result valid
//   out_ready  in   1          consumer accepts result
//   out_data   out  OUT_W      sum_i in_i*w_i, sliced, subject to saturation
//   out_sat    out  1          any slice partial of this result saturated
//   busy       out  1          state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; out_valid=0, out_data=0, out_sat=0, w_err=0, busy=0;
//     all weight registers cleared to 0. in_ready=1 once rst_n=1.
//   FSM states: IDLE -> COMPUTE on in_valid&&in_ready.
//     COMPUTE -> DONE after NSLICE slice cycles.
//     DONE -> IDLE on out_ready&&!in_valid.
//     DONE -> COMPUTE on out_ready&&in_valid, which is a back-to-back accept.
//   in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational.
//   Accept: latch in_data and in_bank; zero-extend each tap at the MSB to NSLICE*SLICE bits.
//     Set acc=0, sat=0, slice counter to NSLICE-1. Slices are processed MSB-first.
//   COMPUTE, each cycle:
//     p = sum_i slice_i * W[bank][i], clipped to 2^ADC_P-1.
//     acc <= (acc<<SLICE) + p. sat |= clipped. The counter decrements.
//     On the counter reaching 0, go to DONE.
//   Latency: accept in cycle T gives out_valid=1 in cycle T+NSLICE+1, i.e. NSLICE compute cycles.
//   DONE: out_valid=1; out_data and out_sat hold stable until out_ready. They drop in the cycle
//     after the handshake unless a back-to-back accept occurred, in which case out_valid=0 during COMPUTE.
//   Weight writes: honoured only in IDLE, taking effect the next cycle.
//     In COMPUTE or DONE, or with w_idx>=N, the write is dropped and w_err pulses 1 cycle.
//     A write and an accept in the same IDLE cycle: the write lands first.
//     That window therefore uses the new weight.
//   Arithmetic: all unsigned. With the defaults the maximum partial is 25*7*255 = 44625 < 2^16,
//     so there is no saturation. OUT_W holds the worst case with no wrap.
//   Mid-operation reset aborts immediately. The result is lost; nothing is partially emitted.
// STRUCTURE
//   pim_conv_pkg holds:
//     - clogb2 function
//     - FSM state encodings: IDLE=2'd0, COMPUTE=2'd1, DONE=2'd2
//     - derived-width functions (nslice, out_w)
//   Sub-module pim_xbar_mac #(N,SLICE,P_W,ADC_P): combinational crossbar plus ADC model.
//     Inputs: slice vector and bank weight vector. Outputs: p (ADC_P) and clip flag.
//   The parent owns the FSM, weight register file, input latch, shift-add accumulator and handshakes.
// TESTING
//   1 Defaults. Bank0 weights all 1, all taps 1, accept at T -> out_data=25, out_sat=0,
//     out_valid at T+5.
//   2 Bank2 weights all 255, taps all 4095 -> out_data=26105625, out_sat=0.
//     Bank0 result is unaffected when bank0 is reused.
//   3 ADC_P=8 instance. Weights 255, taps all 7 -> slice partials 0,0,0,255 (clipped)
//     -> out_data=255, out_sat=1.
//   4 Hold out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0.
//     Raise out_ready with in_valid=1 -> same-cycle accept, next result after 5 more cycles.
//   5 w_we during COMPUTE, and w_idx=25 in IDLE -> w_err pulse each time.
//     Readback by compute shows the weights unchanged.
//   6 rst_n=0 at slice 2 -> out_valid=0, busy=0 asynchronously.
//     After release, in_ready=1 and taps=1 give out_data=0 because the weights were cleared.

Source files
------------

// File: rtl/pim_conv_pkg.sv
// Shared types and width helpers for the bit-serial KxK PIM convolution engine.
package pim_conv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // ceil(log2(v)); 0 for v <= 1
  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // index width that never collapses to zero bits
  function automatic int unsigned clog_min1(input int unsigned v);
    return (clogb2(v) == 0) ? 1 : clogb2(v);
  endfunction

  function automatic int unsigned nslice(input int unsigned p_in, input int unsigned slice);
    return (p_in + slice - 1) / slice;
  endfunction

  function automatic int unsigned out_w(input int unsigned adc_p, input int unsigned p_in,
                                        input int unsigned slice);
    return adc_p + nslice(p_in, slice) * slice;
  endfunction

endpackage

// File: rtl/pim_xbar_mac.sv
// Combinational crossbar dot product of one input bit-slice against a weight
// bank, followed by an ADC model that saturates at 2^ADC_P-1.
module pim_xbar_mac
  import pim_conv_pkg::*;
#(
  parameter int N     = 25,
  parameter int SLICE = 3,
  parameter int P_W   = 8,
  parameter int ADC_P = 16
) (
  input  logic [N*SLICE-1:0] slice_vec,
  input  logic [N*P_W-1:0]   w_vec,
  output logic [ADC_P-1:0]   p,
  output logic               clip
);

  localparam int unsigned RAW_W = SLICE + P_W + clog_min1(N);
  localparam int unsigned SUM_W = (RAW_W > ADC_P) ? RAW_W : ADC_P + 1;

  logic [SUM_W-1:0] sum;

  // Analogue column sum, then clip anything above the ADC full scale
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = sum + SUM_W'(slice_vec[i*SLICE +: SLICE]) * SUM_W'(w_vec[i*P_W +: P_W]);
    end
    clip = |sum[SUM_W-1:ADC_P];
    p    = clip ? '1 : sum[ADC_P-1:0];
  end

endmodule

// File: rtl/conv_kxk_bitserial_pim.sv
// KxK convolution engine: one crossbar time-multiplexed over input bit-slices
// (MSB first), recombined by shift-and-add, with banked weights and handshakes.
module conv_kxk_bitserial_pim
  import pim_conv_pkg::*;
#(
  parameter int K     = 5,
  parameter int P_IN  = 12,
  parameter int P_W   = 8,
  parameter int SLICE = 3,
  parameter int ADC_P = 16,
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 w_we,
  input  logic [clog_min1(DEPTH)-1:0]          w_bank,
  input  logic [clog_min1(K*K)-1:0]            w_idx,
  input  logic [P_W-1:0]                       w_data,
  output logic                                 w_err,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [K*K*P_IN-1:0]                  in_data,
  input  logic [clog_min1(DEPTH)-1:0]          in_bank,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [out_w(ADC_P, P_IN, SLICE)-1:0] out_data,
  output logic                                 out_sat,
  output logic                                 busy
);

  localparam int unsigned N  = K * K;
  localparam int unsigned NS = nslice(P_IN, SLICE);
  localparam int unsigned SW = NS * SLICE;
  localparam int unsigned OW = out_w(ADC_P, P_IN, SLICE);
  localparam int unsigned BW = clog_min1(DEPTH);
  localparam int unsigned CW = clog_min1(NS);

  state_t             state;
  logic [P_W-1:0]     wmem [DEPTH][N];
  logic [N*SW-1:0]    tap_q;
  logic [BW-1:0]      bank_q;
  logic [CW-1:0]      cnt;
  logic [OW-1:0]      acc;
  logic [OW-1:0]      acc_next;
  logic               sat;
  logic [N*SLICE-1:0] slice_vec;
  logic [N*P_W-1:0]   w_vec;
  logic [ADC_P-1:0]   p;
  logic               clip;
  logic               w_ok;
  logic               accept;

  assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign w_ok     = w_we && (state == IDLE) && (32'(w_idx) < N) && (32'(w_bank) < DEPTH);
  assign acc_next = (acc << SLICE) + OW'(p);

  // Present the current slice of every tap and the selected bank to the crossbar
  always_comb begin
    slice_vec = '0;
    w_vec     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      slice_vec[i*SLICE +: SLICE] = tap_q[i*SW + 32'(cnt)*SLICE +: SLICE];
      w_vec[i*P_W +: P_W]         = wmem[bank_q][i];
    end
  end

  pim_xbar_mac #(
    .N    (N),
    .SLICE(SLICE),
    .P_W  (P_W),
    .ADC_P(ADC_P)
  ) u_xbar (
    .slice_vec(slice_vec),
    .w_vec    (w_vec),
    .p        (p),
    .clip     (clip)
  );

  // FSM, weight file, input latch and shift-add accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      w_err     <= 1'b0;
      tap_q     <= '0;
      bank_q    <= '0;
      cnt       <= '0;
      acc       <= '0;
      sat       <= 1'b0;
      for (int unsigned b = 0; b < DEPTH; b++) begin
        for (int unsigned i = 0; i < N; i++) wmem[b][i] <= '0;
      end
    end else begin
      w_err <= w_we && !w_ok;
      if (w_ok) wmem[w_bank][w_idx] <= w_data;

      case (state)
        COMPUTE: begin
          acc <= acc_next;
          sat <= sat | clip;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= acc_next;
            out_sat   <= sat | clip;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!in_valid) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: ;
      endcase

      // Accept from IDLE or back-to-back from DONE; placed last so it
      // overrides the state update of the case above
      if (accept) begin
        state  <= COMPUTE;
        busy   <= 1'b1;
        bank_q <= in_bank;
        acc    <= '0;
        sat    <= 1'b0;
        cnt    <= CW'(NS - 1);
        for (int unsigned i = 0; i < N; i++) begin
          tap_q[i*SW +: SW] <= SW'(in_data[i*P_IN +: P_IN]);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_kxk_bitserial_pim.sv
// Self-checking bench: default engine plus an ADC_P=8 copy driven identically.
module tb_conv_kxk_bitserial_pim;

  localparam int N  = 25;
  localparam int NS = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         w_we;
  logic [1:0]   w_bank;
  logic [4:0]   w_idx;
  logic [7:0]   w_data;
  logic         in_valid;
  logic [299:0] in_data;
  logic [1:0]   in_bank;
  logic         out_ready;

  logic         a_w_err, a_in_ready, a_out_valid, a_out_sat, a_busy;
  logic [27:0]  a_out_data;
  logic         b_w_err, b_in_ready, b_out_valid, b_out_sat, b_busy;
  logic [19:0]  b_out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned wm [4][N];
  int unsigned taps [N];

  always #5 clk = ~clk;

  conv_kxk_bitserial_pim u_a (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_bank(w_bank), .w_idx(w_idx), .w_data(w_data),
    .w_err(a_w_err), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_bank(in_bank), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .busy(a_busy)
  );

  conv_kxk_bitserial_pim #(.ADC_P(8)) u_b (
    .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_bank(w_bank), .w_idx(w_idx), .w_data(w_data),
    .w_err(b_w_err), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_bank(in_bank), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full-precision dot product: the default ADC never saturates
  function automatic longint unsigned dot(input int bank);
    longint unsigned s = 0;
    for (int i = 0; i < N; i++) s += longint'(taps[i]) * longint'(wm[bank][i]);
    return s;
  endfunction

  // Slice-wise result with ADC clipping, slices taken MSB-first
  function automatic longint unsigned sliced(input int bank, input int adc, output bit sat);
    longint unsigned acc = 0;
    longint unsigned pp;
    longint unsigned lim = (64'd1 << adc) - 1;
    sat = 1'b0;
    for (int s = NS - 1; s >= 0; s--) begin
      pp = 0;
      for (int i = 0; i < N; i++) pp += longint'((taps[i] / (8 ** s)) % 8) * longint'(wm[bank][i]);
      if (pp > lim) begin
        pp  = lim;
        sat = 1'b1;
      end
      acc = acc * 8 + pp;
    end
    return acc;
  endfunction

  task automatic write_w(input int bank, input int idx, input int data, input bit expect_err);
    w_we   = 1'b1;
    w_bank = 2'(bank);
    w_idx  = 5'(idx);
    w_data = 8'(data);
    tick();
    w_we = 1'b0;
    check("w_err", 64'(a_w_err), 64'(expect_err));
    if (!expect_err) wm[bank][idx] = 32'(data);
  endtask

  task automatic load_bank(input int bank, input int val, input bit rnd);
    for (int i = 0; i < N; i++) write_w(bank, i, rnd ? int'($urandom_range(0, 255)) : val, 1'b0);
  endtask

  task automatic set_taps(input int val, input bit rnd);
    for (int i = 0; i < N; i++) begin
      taps[i] = rnd ? $urandom_range(0, 4095) : 32'(val);
      in_data[i*12 +: 12] = 12'(taps[i]);
    end
  endtask

  task automatic start(input int bank);
    in_bank  = 2'(bank);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int bank);
    longint unsigned ea, eb;
    bit sb;
    ea = dot(bank);
    eb = sliced(bank, 8, sb);
    check({tag, ":a_valid"}, 64'(a_out_valid), 64'd1);
    check({tag, ":a_data"}, 64'(a_out_data), ea);
    check({tag, ":a_sat"}, 64'(a_out_sat), 64'd0);
    check({tag, ":b_valid"}, 64'(b_out_valid), 64'd1);
    check({tag, ":b_data"}, 64'(b_out_data), eb);
    check({tag, ":b_sat"}, 64'(b_out_sat), 64'(sb));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ":valid_drop"}, 64'(a_out_valid), 64'd0);
    check({tag, ":idle"}, 64'(a_busy), 64'd0);
  endtask

  task automatic run(input string tag, input int bank);
    int n;
    check({tag, ":in_ready"}, 64'(a_in_ready), 64'd1);
    start(bank);
    check({tag, ":busy"}, 64'(a_busy), 64'd1);
    wait_valid(n);
    check({tag, ":latency"}, 64'(n), 64'(NS));
    check_result(tag, bank);
    release_out(tag);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; w_we = 1'b0; w_bank = '0; w_idx = '0; w_data = '0;
    in_valid = 1'b0; in_data = '0; in_bank = '0; out_ready = 1'b0;
    for (int b = 0; b < 4; b++) for (int i = 0; i < N; i++) wm[b][i] = 0;

    // Reset state
    #12;
    check("rst:out_valid", 64'(a_out_valid), 64'd0);
    check("rst:out_data", 64'(a_out_data), 64'd0);
    check("rst:out_sat", 64'(a_out_sat), 64'd0);
    check("rst:busy", 64'(a_busy), 64'd0);
    check("rst:w_err", 64'(a_w_err), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst:in_ready", 64'(a_in_ready), 64'd1);
    tick();

    // 1: unit weights, unit taps
    load_bank(0, 1, 1'b0);
    set_taps(1, 1'b0);
    run("t1", 0);
    check("t1:sum25", 64'(a_out_data), 64'd25);

    // 2: full-scale bank2, then bank0 reused
    load_bank(2, 255, 1'b0);
    set_taps(4095, 1'b0);
    run("t2", 2);
    check("t2:max", 64'(a_out_data), 64'd26105625);
    set_taps(1, 1'b0);
    run("t2b", 0);
    check("t2b:bank0", 64'(a_out_data), 64'd25);

    // 3: narrow ADC saturates on the LSB slice
    set_taps(7, 1'b0);
    run("t3", 2);
    check("t3:b255", 64'(b_out_data), 64'd255);
    check("t3:bsat", 64'(b_out_sat), 64'd1);
    check("t3:a44625", 64'(a_out_data), 64'd44625);

    // Randomized weights and windows against the reference model
    load_bank(1, 0, 1'b1);
    load_bank(3, 0, 1'b1);
    for (int r = 0; r < 8; r++) begin
      set_taps(0, 1'b1);
      run("rand", int'($urandom_range(0, 3)));
    end

    // 4: backpressure in DONE, then back-to-back accept
    set_taps(0, 1'b1);
    start(3);
    wait_valid(n);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t4:hold_data", 64'(a_out_data), dot(3));
      check("t4:hold_valid", 64'(a_out_valid), 64'd1);
      check("t4:in_ready_low", 64'(a_in_ready), 64'd0);
    end
    set_taps(0, 1'b1);
    in_bank = 2'd1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("t4:in_ready_b2b", 64'(a_in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("t4:valid_low", 64'(a_out_valid), 64'd0);
    check("t4:busy", 64'(a_busy), 64'd1);
    wait_valid(n);
    check("t4:latency", 64'(n), 64'(NS));
    check_result("t4", 1);
    release_out("t4");

    // 5: dropped writes (busy and out-of-range index)
    set_taps(1, 1'b0);
    start(0);
    w_we = 1'b1; w_bank = 2'd0; w_idx = 5'd0; w_data = 8'd99;
    tick();
    w_we = 1'b0;
    check("t5:err_busy", 64'(a_w_err), 64'd1);
    tick();
    check("t5:err_pulse", 64'(a_w_err), 64'd0);
    wait_valid(n);
    check_result("t5a", 0);
    release_out("t5a");
    write_w(0, 25, 77, 1'b1);
    tick();
    check("t5:err_clear", 64'(a_w_err), 64'd0);
    run("t5b", 0);
    check("t5b:unchanged", 64'(a_out_data), 64'd25);

    // 6: reset mid-compute clears everything including weights
    set_taps(1, 1'b0);
    start(0);
    tick();
    check("t6:busy_pre", 64'(a_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6:valid_async", 64'(a_out_valid), 64'd0);
    check("t6:busy_async", 64'(a_busy), 64'd0);
    #2 rst_n = 1'b1;
    for (int b = 0; b < 4; b++) for (int i = 0; i < N; i++) wm[b][i] = 0;
    tick();
    check("t6:no_emit", 64'(a_out_valid), 64'd0);
    run("t6", 0);
    check("t6:zero", 64'(a_out_data), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
